alu_instr_sequencer: RTL and testbench



---
 rtl/seq_pkg.sv | 46 ++++
 rtl/instr_fifo.sv | 54 +++++
 rtl/alu_instr_sequencer.sv | 103 ++++++++++
 tb/tb_alu_instr_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding, instruction field layout and ALU funct codes
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2
  } state_t;

  // Bit positions of the R-type fields inside the 32-bit instruction word
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;

  // Function codes understood by the ALU
  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // Decoded R-type fields; the opcode is never stored
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  function automatic instr_t decode_instr(input logic [25:0] w);
    instr_t f;
    f.rs    = w[RS_LSB+:5];
    f.rt    = w[RT_LSB+:5];
    f.rd    = w[RD_LSB+:5];
    f.shamt = w[SHAMT_LSB+:5];
    f.funct = w[FUNCT_LSB+:6];
    return f;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous FIFO holding decoded instructions
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 26
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses a push even when the same cycle pops
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage array write; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// rtl/alu_instr_sequencer.sv - sequences regbank reads, ALU op and writeback per R-type instruction
module alu_instr_sequencer
  import seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32,
  parameter int RADDR_W    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [31:0]        in_instr,
  output logic               in_ready,
  output logic [RADDR_W-1:0] rf_rs,
  output logic [RADDR_W-1:0] rf_rt,
  output logic [RADDR_W-1:0] rf_rd,
  output logic               rf_we,
  output logic [4:0]         alu_shamt,
  output logic [5:0]         alu_funct,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               res_valid,
  output logic [DATA_W-1:0]  res_data,
  output logic [RADDR_W-1:0] res_rd,
  output logic               busy
);

  state_t   state;
  instr_t   cur;
  instr_t   fifo_rdata;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_pop;
  logic     unused_opcode;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

  // Opcode bits are deliberately ignored: every word is treated as R-type
  assign unused_opcode = ^in_instr[31:26];

  // Pop exactly when the FSM latches a new instruction
  assign fifo_pop = (state == S_IDLE || state == S_EXEC) && !fifo_empty;

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(instr_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .wdata (decode_instr(in_instr[25:0])),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

  assign in_ready  = ~fifo_full;
  assign busy      = (state != S_IDLE) || !fifo_empty;
  assign rf_rs     = RADDR_W'(cur.rs);
  assign rf_rt     = RADDR_W'(cur.rt);
  assign rf_rd     = RADDR_W'(cur.rd);
  assign alu_shamt = cur.shamt;
  assign alu_funct = cur.funct;
  // Write strobe comes straight from state; reset suppresses the in-flight write
  assign rf_we     = (state == S_EXEC) && !reset;

  // Main sequencer: IDLE -> DECODE -> EXEC, chaining EXEC -> DECODE when work is queued
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cur       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur   <= fifo_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          state <= S_EXEC;
        end
        S_EXEC: begin
          res_valid <= 1'b1;
          res_data  <= alu_result;
          res_rd    <= RADDR_W'(cur.rd);
          if (!fifo_empty) begin
            cur   <= fifo_rdata;
            state <= S_DECODE;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb/tb_alu_instr_sequencer.sv - randomized self-checking bench with regbank/ALU environment and in-order result model
module tb_alu_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [4:0]  rf_rs, rf_rt, rf_rd;
  logic        rf_we;
  logic [4:0]  alu_shamt;
  logic [5:0]  alu_funct;
  logic [31:0] alu_result;
  logic        res_valid;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        busy;

  alu_instr_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_rd(rf_rd), .rf_we(rf_we),
    .alu_shamt(alu_shamt), .alu_funct(alu_funct), .alu_result(alu_result),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_ADD = 6'h20, F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_SLT = 6'h2A;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] sh, input logic [5:0] fn);
    case (fn)
      F_ADD:   return a + b;
      F_SUB:   return a - b;
      F_AND:   return a & b;
      F_OR:    return a | b;
      F_XOR:   return a ^ b;
      F_SLL:   return b << sh;
      F_SRL:   return b >> sh;
      F_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Environment: register bank (r0 reads zero, writes to r0 dropped) and registered ALU
  logic [31:0] bank [32];
  logic        pre_en = 1'b0;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_en) bank[pre_addr] <= pre_data;
    else if (rf_we && rf_rd != 5'd0) bank[rf_rd] <= alu_result;
    alu_result <= alu_fn((rf_rs == 5'd0) ? 32'd0 : bank[rf_rs],
                         (rf_rt == 5'd0) ? 32'd0 : bank[rf_rt], alu_shamt, alu_funct);
  end

  // Reference model: program-order results from a shadow register file
  typedef struct { logic [4:0] rd; logic [31:0] d; } exp_t;
  typedef struct { int c; logic [4:0] rd; logic [31:0] d; } obs_t;
  exp_t        exp_q[$];
  obs_t        obs_q[$];
  int          drained_cyc[$];
  logic [31:0] shadow [32];
  int          total = 0;
  int          bad = 0;
  int          stalls = 0;

  always @(negedge clk) begin
    if (res_valid === 1'b1) obs_q.push_back('{cyc, res_rd, res_data});
  end

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [4:0] sh, input logic [5:0] fn);
    logic [5:0] op;
    op = 6'($urandom_range(0, 63));
    return {op, rs, rt, rd, sh, fn};
  endfunction

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
    if (a != 5'd0) shadow[a] = d;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge N (cyc == N)
  task automatic push_word(input logic [31:0] w, output int n);
    int g = 0;
    exp_t e;
    in_valid = 1'b1; in_instr = w;
    while (in_ready !== 1'b1 && g < 200) begin @(negedge clk); g++; stalls++; end
    if (g >= 200) begin
      total++; bad++;
      $display("FAIL push_timeout in_ready=%b required=1", in_ready);
    end
    @(negedge clk);
    n = cyc;
    in_valid = 1'b0;
    e.d  = alu_fn(shadow[w[25:21]], shadow[w[20:16]], w[10:6], w[5:0]);
    e.rd = w[15:11];
    if (e.rd != 5'd0) shadow[e.rd] = e.d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int g = 0;
    exp_t e;
    obs_t o;
    drained_cyc.delete();
    while ((obs_q.size() < exp_q.size() || busy) && g < 500) begin @(negedge clk); g++; end
    repeat (3) @(negedge clk);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s_count results=%0d required=%0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      drained_cyc.push_back(o.c);
      total++;
      if (o.rd !== e.rd || o.d !== e.d) begin
        bad++;
        $display("FAIL %s_result rd=%0d data=%h required rd=%0d data=%h", name, o.rd, o.d, e.rd, e.d);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset;
    in_valid = 1'b0; in_instr = '0; reset = 1'b1;
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++;
    if ({in_ready, busy, rf_we, res_valid} !== 4'b1000) begin
      bad++; $display("FAIL reset_flags ready/busy/we/valid=%b required=1000", {in_ready, busy, rf_we, res_valid});
    end
    total++;
    if ({rf_rs, rf_rt, rf_rd, alu_shamt, alu_funct, res_rd} !== '0 || res_data !== 32'd0) begin
      bad++; $display("FAIL reset_fields rs=%0d rt=%0d rd=%0d sh=%0d fn=%0d res_rd=%0d res_data=%h required all 0",
                      rf_rs, rf_rt, rf_rd, alu_shamt, alu_funct, res_rd, res_data);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || rf_we !== 1'b0 || res_valid !== 1'b0) begin
        bad++; $display("FAIL idle_quiet busy=%b we=%b valid=%b required 000", busy, rf_we, res_valid);
      end
    end
  endtask

  task automatic test_single_add;
    int n;
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    push_word(mk(5'd1, 5'd2, 5'd3, 5'd0, F_ADD), n);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (rf_we !== (k == 2) || res_valid !== (k == 3)) begin
        bad++; $display("FAIL add_timing k=%0d we=%b valid=%b required we=%b valid=%b", k, rf_we, res_valid, k == 2, k == 3);
      end
      if (k == 1) begin
        total++;
        if (rf_rs !== 5'd1 || rf_rt !== 5'd2 || alu_funct !== F_ADD) begin
          bad++; $display("FAIL add_decode rs=%0d rt=%0d fn=%h required 1 2 20", rf_rs, rf_rt, alu_funct);
        end
      end
      if (k == 2) begin
        total++;
        if (rf_rd !== 5'd3) begin bad++; $display("FAIL add_rd rf_rd=%0d required 3", rf_rd); end
      end
      if (k == 3) begin
        total++;
        if (res_data !== 32'd12 || res_rd !== 5'd3) begin
          bad++; $display("FAIL add_result data=%0d rd=%0d required 12 3", res_data, res_rd);
        end
      end
      @(negedge clk);
    end
    drain("add");
  endtask

  task automatic test_dependent;
    int n;
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    push_word(mk(5'd1, 5'd2, 5'd3, 5'd0, F_ADD), n);
    push_word(mk(5'd3, 5'd1, 5'd4, 5'd0, F_ADD), n);
    total++;
    if (exp_q[0].d !== 32'd12 || exp_q[1].d !== 32'd17) begin
      bad++; $display("FAIL dep_model got %0d %0d required 12 17", exp_q[0].d, exp_q[1].d);
    end
    drain("dep");
    total++;
    if (drained_cyc.size() != 2 || drained_cyc[1] - drained_cyc[0] != 2) begin
      bad++; $display("FAIL dep_spacing pulses=%0d gap=%0d required 2 2", drained_cyc.size(),
                      (drained_cyc.size() == 2) ? drained_cyc[1] - drained_cyc[0] : -1);
    end
  endtask

  task automatic test_fifo_full;
    int n;
    stalls = 0;
    for (int i = 1; i < 8; i++) preload(5'(i), 32'($urandom));
    for (int i = 0; i < 10; i++)
      push_word(mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(1, 7)),
                   5'($urandom_range(0, 31)), F_XOR), n);
    total++;
    if (stalls == 0) begin bad++; $display("FAIL full_backpressure stalls=%0d required >0", stalls); end
    drain("full");
  endtask

  task automatic test_shift;
    int n;
    preload(5'd1, 32'h0000_00F0);
    push_word(mk(5'd0, 5'd1, 5'd5, 5'd4, F_SLL), n);
    total++;
    if (exp_q[0].d !== 32'h0000_0F00) begin bad++; $display("FAIL sll_model got %h required 00000f00", exp_q[0].d); end
    drain("sll");
  endtask

  task automatic test_random;
    int n;
    logic [5:0] fns [8];
    fns = '{F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLL, F_SRL, F_SLT};
    for (int i = 1; i < 32; i++) preload(5'(i), 32'($urandom));
    for (int i = 0; i < 30; i++) begin
      push_word(mk(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), fns[$urandom_range(0, 7)]), n);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain("rand");
  endtask

  task automatic test_reset_mid_op;
    int n;
    preload(5'd10, 32'hAAAA_0010);
    preload(5'd11, 32'hAAAA_0011);
    preload(5'd12, 32'hAAAA_0012);
    push_word(mk(5'd10, 5'd11, 5'd10, 5'd0, F_ADD), n);
    push_word(mk(5'd10, 5'd11, 5'd11, 5'd0, F_SUB), n);
    push_word(mk(5'd10, 5'd11, 5'd12, 5'd0, F_OR), n);
    total++;
    if (rf_we !== 1'b1) begin bad++; $display("FAIL mid_exec we=%b required 1", rf_we); end
    reset = 1'b1;
    #1;
    total++;
    if (rf_we !== 1'b0) begin bad++; $display("FAIL mid_we_gated we=%b required 0", rf_we); end
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_state busy=%b ready=%b required 0 1", busy, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (rf_we !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL mid_quiet we=%b valid=%b busy=%b required 000", rf_we, res_valid, busy);
      end
    end
    total++;
    if (bank[10] !== 32'hAAAA_0010 || bank[11] !== 32'hAAAA_0011 || bank[12] !== 32'hAAAA_0012) begin
      bad++; $display("FAIL mid_no_write r10=%h r11=%h r12=%h required aaaa0010 aaaa0011 aaaa0012",
                      bank[10], bank[11], bank[12]);
    end
    exp_q.delete();
    obs_q.delete();
    for (int i = 1; i < 32; i++) shadow[i] = bank[i];
    test_single_add();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0;
    @(negedge clk);
    test_reset();
    test_single_add();
    test_dependent();
    test_fifo_full();
    test_shift();
    test_random();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d required finish", cyc);
    $fatal(1);
  end

endmodule
